pool_line_buffer: RTL and testbench
===================================

# pool_line_buffer

Streaming 2x2 stride-2 pooling stage for the CNN datapath: accepts one signed fixed-point pixel per cycle in raster order and emits one pooled value per 2x2 window. It succeeds the fixed 31-entry pooling buffer with three changes: parametrised line width, a registered valid/ready handshake on both sides, and selectable max or average pooling. It sits between the convolution/activation output and the next layer's input buffer.

## Interface
- INTEGER_BITS, 9, integer bits of the signed fixed-point sample
- FIXED_POINT_BITS, 4, fractional bits; W = INTEGER_BITS+FIXED_POINT_BITS
- LINE_WIDTH, 32, pixels per input row; even, >= 2
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_data  in  W  input pixel, two's complement
- i_valid  in  1  input pixel valid
- o_ready  out  1  block can accept i_data this cycle
- i_mode  in  1  0 = max pool, 1 = average pool; sampled per window
- o_data  out  W  pooled result, two's complement
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts o_data
- o_row_last  out  1  qualifies o_data as last window of an output row

## Operation
- Input transfer: i_valid && o_ready. Output transfer: o_valid && i_ready.
- o_ready = !o_valid || i_ready (single output register, no bubble).
- Counters: col (0..LINE_WIDTH-1) and row parity bit; both advance only on input transfer. col wraps to 0 after LINE_WIDTH-1, toggling parity.
- Even row (parity 0): pixel written to line[col]. No output.
- Odd row, even col: pixel captured in hold register; no output.
- Odd row, odd col: window = {line[col-1], line[col], hold, i_data}; result loaded into o_data, o_valid set, o_row_last = (col == LINE_WIDTH-1).
- Max: signed compare, largest of four; ties irrelevant.
- Average: sum sign-extended to W+2 bits, arithmetic shift right 2 (floor toward -inf), low W bits taken; no saturation needed.
- Line memory: LINE_WIDTH x W, not reset; contents after reset are don't-care and always overwritten before use.
- i_mode sampled on the transfer that completes the window.

## Timing
- Reset values: o_valid 0, o_data 0, o_row_last 0, col 0, parity 0; o_ready 1 in first cycle after reset.
- Latency: o_valid asserts the cycle after the input transfer completing a window.
- o_data/o_row_last stable while o_valid && !i_ready.
- Simultaneous output transfer and new window completion: o_data reloads same edge, o_valid stays 1.
- Back-pressure: with o_valid && !i_ready, o_ready = 0; input held off, counters frozen.
- i_valid low: no state change except output drain.
- Reset mid-row or mid-stall: partial row and pending output discarded; next accepted pixel is row 0 col 0.
- Throughput: one pixel per cycle sustained when i_ready held high.

## Configuration
- POOL_AVG_EN defined: adder tree and shifter built; i_mode selects max/average as above.
- POOL_AVG_EN undefined: average path absent; i_mode ignored, always max pool.

## Test plan
- LINE_WIDTH=4, max mode, rows [1,2,3,4],[5,6,7,8] (integer values << 4) -> two outputs 6<<4, 8<<4; o_row_last 0 then 1; one-cycle latency each.
- Average mode, window {-1,-2,3,4} (fixed-point, <<4) -> sum 64, result 16 (1.0); window {-1,-1,-1,-2} raw LSBs -> sum -5, result -2 (floor).
- Max mode, all-negative window {-100,-3,-50,-7} raw -> -3.
- Hold i_ready low with output pending, i_valid high -> o_ready 0, o_data unchanged, no pixel lost; release -> stream resumes, outputs match golden model.
- Assert i_rst after 3 pixels of row 1 -> o_valid 0, o_data 0 next cycle; fresh 2-row frame yields correct windows from col 0.
- Build without POOL_AVG_EN, i_mode=1, window {1,2,3,4}<<4 -> output 4<<4.

Source files
------------

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: streaming 2x2 stride-2 max/average pooling over a raster-order pixel stream
// Ports: i_clk, i_rst (sync, active-high); i_data/i_valid/o_ready input pixel handshake;
// o_data/o_valid/i_ready pooled output handshake; o_row_last marks the last window of an output row;
// i_mode picks average (1) or max (0) only when POOL_AVG_EN is defined, otherwise max pooling always.
module pool_line_buffer #(
  parameter int INTEGER_BITS = 9,
  parameter int FIXED_POINT_BITS = 4,
  parameter int LINE_WIDTH = 32
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]  i_data,
  input  logic                                      i_valid,
  output logic                                      o_ready,
  input  logic                                      i_mode,
  output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]  o_data,
  output logic                                      o_valid,
  input  logic                                      i_ready,
  output logic                                      o_row_last
);
  localparam int W = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int CW = $clog2(LINE_WIDTH);
  logic [CW-1:0] col;
  logic parity, in_xfer, col_last, win_done;
  logic signed [W-1:0] line_mem [LINE_WIDTH];
  logic signed [W-1:0] hold, a, b, c, d, m_ab, m_cd, max_v, result;
  assign o_ready = !o_valid || i_ready;
  assign in_xfer = i_valid && o_ready;
  assign col_last = col == CW'(LINE_WIDTH - 1);
  assign win_done = in_xfer && parity && col[0];
  // window completes on an odd column, so the upper-row pair sits at col-1 and col
  assign a = line_mem[col - 1'b1];
  assign b = line_mem[col];
  assign c = hold;
  assign d = i_data;
  always_comb begin
    m_ab = a > b ? a : b;
    m_cd = c > d ? c : d;
    max_v = m_ab > m_cd ? m_ab : m_cd;
  end
`ifdef POOL_AVG_EN
  logic signed [W+1:0] sum;
  assign sum = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} + {{2{c[W-1]}}, c} + {{2{d[W-1]}}, d};
  // arithmetic shift floors toward -inf; the mean of four W-bit values always fits in W bits
  assign result = i_mode ? W'(sum >>> 2) : max_v;
`else
  logic unused_mode;
  assign unused_mode = i_mode;
  assign result = max_v;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col <= '0;
      parity <= 1'b0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_row_last <= 1'b0;
    end else begin
      if (in_xfer) begin
        col <= col_last ? '0 : col + 1'b1;
        parity <= parity ^ col_last;
      end
      if (win_done) begin
        o_data <= result;
        o_valid <= 1'b1;
        o_row_last <= col_last;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end
  // storage only; every entry is rewritten by an even row before any odd row reads it
  always_ff @(posedge i_clk) begin
    if (in_xfer && !parity) line_mem[col] <= i_data;
    if (in_xfer && parity && !col[0]) hold <= i_data;
  end
endmodule

// File: tb/tb_pool_line_buffer.sv
// tb_pool_line_buffer: directed and random checks of pool_line_buffer against a row-based reference model
module tb_pool_line_buffer;
  localparam int W = 13;
  localparam int LW = 4;
`ifdef POOL_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif
  logic clk = 1'b0;
  logic i_rst, i_valid, o_ready, i_mode, o_valid, i_ready, o_row_last;
  logic [W-1:0] i_data, o_data;
  int n_assert = 0;
  int n_fail = 0;
  int prev_row[LW];
  int cur_row[LW];
  int mcol, mrow;
  bit exp_valid, exp_last;
  logic [W-1:0] exp_data;

  pool_line_buffer #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .LINE_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_row_last(o_row_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int fdiv4(input int s);
    int q;
    q = s / 4;
    if (s % 4 != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // drive one cycle; check the outputs against the model, then advance the model across the edge
  task automatic step(input bit v, input int px, input bit mode, input bit rdy);
    bit in_x;
    int win[4];
    int res;
    @(negedge clk);
    i_valid = v;
    i_data = W'(px);
    i_mode = mode;
    i_ready = rdy;
    #1;
    chk("o_valid", o_valid, exp_valid);
    chk("o_ready", o_ready, !exp_valid || rdy);
    if (exp_valid) begin
      chk("o_data", o_data, exp_data);
      chk("o_row_last", o_row_last, exp_last);
    end
    in_x = v && (!exp_valid || rdy);
    if (exp_valid && rdy) exp_valid = 1'b0;
    if (in_x) begin
      cur_row[mcol] = px;
      if (mrow % 2 == 1 && mcol % 2 == 1) begin
        win = '{prev_row[mcol-1], prev_row[mcol], cur_row[mcol-1], cur_row[mcol]};
        if (AVG && mode) res = fdiv4(win[0] + win[1] + win[2] + win[3]);
        else begin
          res = win[0];
          for (int k = 1; k < 4; k++) if (win[k] > res) res = win[k];
        end
        exp_valid = 1'b1;
        exp_data = W'(res);
        exp_last = (mcol == LW - 1);
      end
      mcol++;
      if (mcol == LW) begin
        mcol = 0;
        mrow++;
        prev_row = cur_row;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_data", o_data, '0);
    chk("rst_o_row_last", o_row_last, 1'b0);
    chk("rst_o_ready", o_ready, 1'b1);
    mcol = 0;
    mrow = 0;
    exp_valid = 1'b0;
    exp_data = '0;
    exp_last = 1'b0;
  endtask

  task automatic frame(input int px[8], input bit mode);
    for (int k = 0; k < 7; k++) step(1'b1, px[k], mode, 1'b1);
  endtask

  initial begin
    logic signed [W-1:0] rv;
    int seq[8];
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_mode = 1'b0; i_ready = 1'b1;
    mcol = 0; mrow = 0; exp_valid = 1'b0; exp_data = '0; exp_last = 1'b0;
    do_reset();
    seq = '{16, 32, 48, 64, 80, 96, 112, 128};
    frame(seq, 1'b0);
    chk("max_w0", o_data, W'(96));
    chk("max_w0_last", o_row_last, 1'b0);
    step(1'b1, seq[7], 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("max_w1", o_data, W'(128));
    chk("max_w1_last", o_row_last, 1'b1);
    seq = '{-16, -32, -1, -1, 48, 64, -1, -2};
    frame(seq, 1'b1);
    chk("avg_w0", o_data, AVG ? W'(16) : W'(64));
    step(1'b1, seq[7], 1'b1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    chk("avg_floor", o_data, AVG ? W'(-2) : W'(-1));
    seq = '{-100, -3, 0, 0, -50, -7, 0, 0};
    frame(seq, 1'b0);
    chk("max_neg", o_data, W'(-3));
    step(1'b1, seq[7], 1'b0, 1'b1);
    seq = '{16, 32, 0, 0, 48, 64, 0, 0};
    frame(seq, 1'b1);
    chk("mode1_w0", o_data, AVG ? W'(40) : W'(64));
    step(1'b1, seq[7], 1'b1, 1'b1);
    seq = '{5, 9, 2, 7, 1, 3, 8, 4};
    for (int k = 0; k < 6; k++) step(1'b1, seq[k], 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, seq[6], 1'b0, 1'b0);
    chk("bp_ready", o_ready, 1'b0);
    chk("bp_data", o_data, W'(9));
    step(1'b1, seq[6], 1'b0, 1'b1);
    step(1'b1, seq[7], 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("bp_resume", o_data, W'(8));
    chk("bp_resume_last", o_row_last, 1'b1);
    for (int k = 0; k < 400; k++) begin
      rv = W'($urandom);
      step($urandom_range(3, 0) != 0, int'(rv), 1'($urandom), $urandom_range(9, 0) < 7);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0, 1'b1);
    seq = '{3, 1, 4, 1, 5, 9, 2, 6};
    for (int k = 0; k < 7; k++) step(1'b1, seq[k], 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    do_reset();
    seq = '{-5, 10, 20, -30, 7, -8, 40, 1};
    frame(seq, 1'b0);
    chk("post_rst_w0", o_data, W'(10));
    step(1'b1, seq[7], 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("post_rst_w1", o_data, W'(40));
    for (int k = 0; k < 200; k++) begin
      rv = W'($urandom);
      step(1'b1, int'(rv), 1'($urandom), $urandom_range(3, 0) != 0);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
